// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with clock-count bit timer
//
// Ports:
//   clk          system clock, rising edge
//   nRst         asynchronous active-low reset
//   rx_serial    asynchronous serial line, idles high
//   rx_byte      last correctly received byte, held until the next good frame
//   rx_ready     1-cycle pulse, rx_byte updated this cycle
//   framing_err  1-cycle pulse, stop bit sampled low and the byte discarded
//   busy         high whenever the receiver is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       framing_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state;
    logic             sync1;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= S_IDLE;
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            rx_byte     <= 8'h00;
            rx_ready    <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync1       <= rx_serial;
            rx_s        <= sync1;
            rx_ready    <= 1'b0;
            framing_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end

                // Half a bit in: re-check the start bit so a short low glitch
                // is dropped, and align all later samples to mid-bit.
                S_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == FULL) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leaving at mid-stop gives half a bit of slack to catch a
                // start bit that follows with no idle gap.
                S_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_byte  <= shift;
                            rx_ready <= 1'b1;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A held-low line must return high before a new frame may start.
                S_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int LAT = CPB * 9 + (CPB - 1) / 2 + 3;

    logic       clk;
    logic       nRst;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       framing_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   last_fall_cyc = 0;
    logic [8:0] ev_q[$];
    int   ev_cyc_q[$];
    int   overlap = 0;
    logic busy_seen = 1'b0;
    logic [7:0] model_byte = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .rx_serial  (rx_serial),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .framing_err(framing_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log: bit 8 set = framing error, else a received byte
    always @(negedge clk) begin
        if (nRst) begin
            if (rx_ready) begin
                ev_q.push_back({1'b0, rx_byte});
                ev_cyc_q.push_back(cyc);
            end
            if (framing_err) begin
                ev_q.push_back(9'h100);
                ev_cyc_q.push_back(cyc);
            end
            if (rx_ready && framing_err) overlap = overlap + 1;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic drive_bit(input logic b, input int n);
        rx_serial = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        last_fall_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop_bit, CPB);
    endtask

    task automatic test_reset;
        nRst = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", rx_byte); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
        checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_framing_err got %b want 0", framing_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        nRst = 1'b1;
        drive_bit(1'b1, 10);
    endtask

    task automatic test_single;
        int base;
        base = ev_q.size();
        send_frame(8'h41, 1'b1);
        drive_bit(1'b1, 10);
        model_byte = 8'h41;
        checks++;
        if (ev_q.size() != base + 1) begin
            errors++; $display("FAIL single_count got %0d want 1", ev_q.size() - base);
        end else begin
            checks++; if (ev_q[base] !== 9'h041) begin errors++; $display("FAIL single_event got %h want 041", ev_q[base]); end
            checks++;
            if (ev_cyc_q[base] - last_fall_cyc < LAT - 1 || ev_cyc_q[base] - last_fall_cyc > LAT + 1) begin
                errors++; $display("FAIL single_latency got %0d want %0d+/-1", ev_cyc_q[base] - last_fall_cyc, LAT);
            end
        end
        checks++; if (rx_byte !== model_byte) begin errors++; $display("FAIL single_rx_byte got %h want %h", rx_byte, model_byte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    endtask

    task automatic test_glitch;
        int base;
        base = ev_q.size();
        busy_seen = 1'b0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * CPB);
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b want 1", busy_seen); end
        checks++; if (ev_q.size() != base) begin errors++; $display("FAIL glitch_events got %0d want 0", ev_q.size() - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
        checks++; if (rx_byte !== model_byte) begin errors++; $display("FAIL glitch_rx_byte got %h want %h", rx_byte, model_byte); end
    endtask

    task automatic test_framing;
        int base;
        base = ev_q.size();
        send_frame(8'h55, 1'b0);
        drive_bit(1'b0, CPB);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL framing_break_busy got %b want 1", busy); end
        drive_bit(1'b1, 10);
        checks++;
        if (ev_q.size() != base + 1) begin
            errors++; $display("FAIL framing_count got %0d want 1", ev_q.size() - base);
        end else begin
            checks++; if (ev_q[base] !== 9'h100) begin errors++; $display("FAIL framing_event got %h want 100", ev_q[base]); end
        end
        checks++; if (rx_byte !== model_byte) begin errors++; $display("FAIL framing_rx_byte got %h want %h", rx_byte, model_byte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int base;
        base = ev_q.size();
        send_frame(8'h48, 1'b1);
        send_frame(8'h4D, 1'b1);
        drive_bit(1'b1, 10);
        model_byte = 8'h4D;
        checks++;
        if (ev_q.size() != base + 2) begin
            errors++; $display("FAIL b2b_count got %0d want 2", ev_q.size() - base);
        end else begin
            checks++; if (ev_q[base] !== 9'h048) begin errors++; $display("FAIL b2b_first got %h want 048", ev_q[base]); end
            checks++; if (ev_q[base + 1] !== 9'h04D) begin errors++; $display("FAIL b2b_second got %h want 04D", ev_q[base + 1]); end
            checks++;
            if (ev_cyc_q[base + 1] - ev_cyc_q[base] != 10 * CPB) begin
                errors++; $display("FAIL b2b_spacing got %0d want %0d", ev_cyc_q[base + 1] - ev_cyc_q[base], 10 * CPB);
            end
        end
        checks++; if (rx_byte !== model_byte) begin errors++; $display("FAIL b2b_rx_byte got %h want %h", rx_byte, model_byte); end
    endtask

    task automatic test_random;
        int base;
        logic [8:0] exp_q[$];
        logic [7:0] b;
        logic bad;
        base = ev_q.size();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad);
            if (bad) begin
                drive_bit(1'b0, $urandom_range(0, 20));
                drive_bit(1'b1, 4);
                exp_q.push_back(9'h100);
            end else begin
                exp_q.push_back({1'b0, b});
                model_byte = b;
            end
            drive_bit(1'b1, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30));
        end
        drive_bit(1'b1, 10);
        checks++;
        if (ev_q.size() != base + exp_q.size()) begin
            errors++; $display("FAIL random_count got %0d want %0d", ev_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (ev_q[base + i] !== exp_q[i]) begin
                    errors++; $display("FAIL random_event[%0d] got %h want %h", i, ev_q[base + i], exp_q[i]);
                end
            end
        end
        checks++; if (rx_byte !== model_byte) begin errors++; $display("FAIL random_rx_byte got %h want %h", rx_byte, model_byte); end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        base = ev_q.size();
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, 3 * CPB + CPB / 2);
        nRst = 1'b0;
        #1;
        model_byte = 8'h00;
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL midrst_rx_byte got %h want 00", rx_byte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (rx_ready !== 1'b0 || framing_err !== 1'b0) begin errors++; $display("FAIL midrst_pulses got %b%b want 00", rx_ready, framing_err); end
        drive_bit(1'b1, 3);
        nRst = 1'b1;
        drive_bit(1'b1, 12 * CPB);
        checks++; if (ev_q.size() != base) begin errors++; $display("FAIL midrst_events got %0d want 0", ev_q.size() - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got %b want 0", busy); end
        send_frame(8'h0A, 1'b1);
        drive_bit(1'b1, 10);
        model_byte = 8'h0A;
        checks++;
        if (ev_q.size() != base + 1) begin
            errors++; $display("FAIL midrst_after_count got %0d want 1", ev_q.size() - base);
        end else begin
            checks++; if (ev_q[base] !== 9'h00A) begin errors++; $display("FAIL midrst_after_event got %h want 00A", ev_q[base]); end
        end
        checks++; if (rx_byte !== model_byte) begin errors++; $display("FAIL midrst_after_rx_byte got %h want %h", rx_byte, model_byte); end
    endtask

    task automatic test_long_break;
        int base;
        base = ev_q.size();
        drive_bit(1'b0, 30 * CPB);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", busy); end
        checks++;
        if (ev_q.size() != base + 1) begin
            errors++; $display("FAIL break_count got %0d want 1", ev_q.size() - base);
        end else begin
            checks++; if (ev_q[base] !== 9'h100) begin errors++; $display("FAIL break_event got %h want 100", ev_q[base]); end
        end
        drive_bit(1'b1, 10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_idle_busy got %b want 0", busy); end
        checks++; if (rx_byte !== model_byte) begin errors++; $display("FAIL break_rx_byte got %h want %h", rx_byte, model_byte); end
    endtask

    task automatic test_pulse_overlap;
        checks++; if (overlap != 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", overlap); end
    endtask

    initial begin
        nRst = 1'b0;
        rx_serial = 1'b1;
        test_reset;
        test_single;
        test_glitch;
        test_framing;
        test_back_to_back;
        test_random;
        test_reset_mid_frame;
        test_long_break;
        test_pulse_overlap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
